lm07_slave_model: RTL and testbench
===================================

Name: lm07_slave_model

Overview:
- Synthesizable model of the LM07 serial temperature sensor.
- Sits directly upstream of the LM07 master: it answers the master's chip-select and sclk by shifting a 16-bit temperature word out on sio.
- The temperature value comes from a local source (stimulus counter or ADC stub) through a valid-qualified input, so the full sensor→master→display chain runs on one board.

Parameters:
- SYNC_STAGES, 2, flops in each synchronizer for cs_n and sclk (minimum 2).
- RESET_TEMP, 11'h064, holding-register value after reset (+25.00 °C).

Ports:
- clk  input  1  system clock; sclk and cs_n are sampled on it.
- reset  input  1  synchronous, active-high reset.
- cs_n  input  1  chip select from master, active low.
- sclk  input  1  serial clock from master; idle high.
- temp_in  input  11  signed two's-complement temperature, 0.25 °C/LSB.
- temp_valid  input  1  one-cycle strobe; loads temp_in into the holding register.
- sio  output  1  serial data to master, MSB first.
- sio_oe  output  1  high while a frame is active.
- busy  output  1  high from frame start to frame end.
- frame_done  output  1  one-cycle pulse when a frame closes after at least 16 shifts.

Behaviour:
- Reset values:
  - sio=0, sio_oe=0, busy=0, frame_done=0.
  - bit_cnt=0, state=IDLE, hold_reg=RESET_TEMP.
  - cs_n synchronizer chain resets to 0 and sclk chain to 1, so a cs_n that is high after reset does not create a false falling edge.
- Synchronizers: cs_n and sclk each pass SYNC_STAGES flops, then a one-flop edge detector.
- Master timing: each sclk phase must last at least SYNC_STAGES+2 clk.
- Data word: {hold_snapshot[10:0], 2'b11, 3'b000}.
- Holding register: temp_valid loads hold_reg on any cycle, including mid-frame. The frame always shifts the snapshot taken at frame start.
- IDLE:
  - sio_oe=0, sio=0.
  - Detected cs_n fall → load shift_reg with the data word, sio=word[15], sio_oe=1, busy=1, bit_cnt=0, go to SHIFT.
  - Latency: sio valid SYNC_STAGES+1 clk after the cs_n fall.
- SHIFT:
  - Each detected sclk falling edge shifts left with zero fill, drives the new MSB on sio, and increments bit_cnt. The master samples on the sclk rising edge.
  - bit_cnt reaching 15 → go to TAIL.
  - sclk rising edges do not change sio.
- TAIL:
  - Further falling edges drive sio=0.
  - bit_cnt saturates at 31.
- Frame end: a detected cs_n rise in SHIFT or TAIL → IDLE, sio_oe=0, busy=0, sio=0.
  - frame_done=1 for one clk only if at least 16 falling edges were counted (TAIL reached).
  - A short frame aborts silently, with no frame_done.
- Simultaneous events in the same clk:
  - cs_n rise with an sclk fall: the rise wins and no shift occurs.
  - cs_n fall with temp_valid: the snapshot takes the new temp_in.
- cs_n rise while in IDLE is ignored.
- Reset mid-frame: immediate return to reset values. A new frame needs a fresh detected cs_n fall.

Optional Feature:
- Macro: LM07_CFG_WRITE_EN.
- With the macro defined:
  - Adds ports sio_in (input 1) and cfg_reg (output 16, reset 16'h0000).
  - In TAIL, sio_in is sampled on each detected sclk rising edge into a 16-bit capture register, MSB first.
  - On cs_n rise with exactly 32 falling edges counted, cfg_reg is loaded from the capture register.
  - While cfg_reg==16'hFFFF (shutdown), frames shift the fixed ID word 16'h800F instead of the temperature word.
- Without the macro: there is no sio_in and no cfg_reg, and TAIL only drives zeros.

Decomposition:
- Package lm07_pkg holds:
  - TEMP_W=11, WORD_W=16, STATUS_BITS=2'b11, ID_WORD=16'h800F, SHUTDOWN_CODE=16'hFFFF.
  - The state enum {IDLE, SHIFT, TAIL}.
- Sub-module lm07_edge_sync: parameterized synchronizer plus rise/fall pulse outputs and a reset-value parameter. It is instantiated once for cs_n and once for sclk.

Test Plan:
- temp_in=11'h064 strobed, then a 16-clock frame → master reads 16'h0C98, and frame_done pulses once after cs_n rises.
- temp_in=11'h79C (−25 °C) → 16'hF398, and the sign bit appears on sio before the first sclk fall.
- temp_valid=11'h064 fires at bit 5 of a frame that started with 11'h79C → that frame still returns 16'hF398, and the next frame returns 16'h0C98.
- cs_n rises after 9 sclk falls → sio_oe=0 within SYNC_STAGES+1 clk, no frame_done, and the next full frame is correct.
- reset asserted at bit 8 with cs_n held low → sio=0, sio_oe=0, and no frame restarts until cs_n goes high then low.
- LM07_CFG_WRITE_EN: a 32-clock frame writing 16'hFFFF → cfg_reg=16'hFFFF, and the next read returns 16'h800F; writing 16'h0000 restores temperature reads.

Source files
------------

// File: rtl/lm07_pkg.sv
// Shared constants, FSM state type and data-word builder for the LM07 sensor model.
package lm07_pkg;

    localparam int TEMP_W = 11;
    localparam int WORD_W = 16;

    localparam logic [1:0]        STATUS_BITS   = 2'b11;
    localparam logic [WORD_W-1:0] ID_WORD       = 16'h800F;
    localparam logic [WORD_W-1:0] SHUTDOWN_CODE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    // Temperature word as the master sees it: value, two status ones, three zeros.
    function automatic logic [WORD_W-1:0] make_word(input logic [TEMP_W-1:0] temp);
        return {temp, STATUS_BITS, 3'b000};
    endfunction

endpackage

// File: rtl/lm07_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input with single-cycle
// rise/fall pulses. RESET_VAL presets the whole chain so that an input already
// sitting at its idle level after reset does not look like an edge.
// STAGES must be at least 2.
module lm07_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus the one-flop history used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = ~prev_q &  sync_q[STAGES-1];
    assign fall =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/lm07_slave_model.sv
// LM07 serial temperature sensor model: shifts a 16-bit word out on sio under
// the master's cs_n/sclk. Optional configuration write-back is enabled with
// the LM07_CFG_WRITE_EN macro (adds sio_in and cfg_reg).
module lm07_slave_model
    import lm07_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [TEMP_W-1:0] RESET_TEMP  = 11'h064
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic              temp_valid,
    output logic              sio,
    output logic              sio_oe,
    output logic              busy,
`ifdef LM07_CFG_WRITE_EN
    input  logic              sio_in,
    output logic [WORD_W-1:0] cfg_reg,
`endif
    output logic              frame_done
);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;

    // cs_n chain presets low so a high cs_n out of reset is not a falling edge.
    lm07_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    lm07_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    state_t              state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [4:0]          bit_cnt_q;
    logic [TEMP_W-1:0]   hold_q;
    logic                sio_q, sio_oe_q, busy_q, done_q;
    logic                shutdown;
    logic [TEMP_W-1:0]   snap_temp_d;
    logic [WORD_W-1:0]   word_d;

`ifdef LM07_CFG_WRITE_EN
    logic [WORD_W-1:0] cap_q;
    logic [WORD_W-1:0] cfg_q;
    logic [5:0]        fall_cnt_q;

    // Config capture: counts falls per frame, shifts in sio_in on TAIL rises,
    // commits only for a frame of exactly 32 falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q      <= '0;
            cfg_q      <= '0;
            fall_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && cs_fall) begin
                fall_cnt_q <= '0;
            end else if (state_q != IDLE && !cs_rise && sclk_fall && fall_cnt_q != 6'd63) begin
                fall_cnt_q <= fall_cnt_q + 6'd1;
            end
            if (state_q == TAIL && !cs_rise && sclk_rise) begin
                cap_q <= {cap_q[WORD_W-2:0], sio_in};
            end
            if (state_q != IDLE && cs_rise && fall_cnt_q == 6'd32) begin
                cfg_q <= cap_q;
            end
        end
    end

    assign shutdown = (cfg_q == SHUTDOWN_CODE);
    assign cfg_reg  = cfg_q;
`else
    logic unused_sclk_rise;
    assign unused_sclk_rise = sclk_rise;
    assign shutdown         = 1'b0;
`endif

    // Snapshot source: a strobe coinciding with the frame start wins over the held value.
    always_comb begin
        snap_temp_d = temp_valid ? temp_in : hold_q;
        word_d      = shutdown ? ID_WORD : make_word(snap_temp_d);
    end

    // Frame FSM with registered sio/sio_oe/busy/frame_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            hold_q    <= RESET_TEMP;
            sio_q     <= 1'b0;
            sio_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (temp_valid) begin
                hold_q <= temp_in;
            end
            case (state_q)
                IDLE: begin
                    sio_q    <= 1'b0;
                    sio_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (cs_fall) begin
                        shift_q   <= word_d;
                        sio_q     <= word_d[WORD_W-1];
                        sio_oe_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Short frame: abort without frame_done.
                        state_q  <= IDLE;
                        sio_q    <= 1'b0;
                        sio_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (sclk_fall) begin
                        shift_q   <= {shift_q[WORD_W-2:0], 1'b0};
                        sio_q     <= shift_q[WORD_W-2];
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd14) begin
                            state_q <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (cs_rise) begin
                        state_q  <= IDLE;
                        sio_q    <= 1'b0;
                        sio_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= (bit_cnt_q >= 5'd16);
                    end else if (sclk_fall) begin
                        shift_q <= {shift_q[WORD_W-2:0], 1'b0};
                        sio_q   <= 1'b0;
                        if (bit_cnt_q != 5'd31) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sio        = sio_q;
    assign sio_oe     = sio_oe_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lm07_slave_model.sv
// Directed bench for lm07_slave_model acting as the LM07 master.
// Define LM07_CFG_WRITE_EN to also exercise the config write-back path.
`timescale 1ns/1ps
module tb_lm07_slave_model;

    localparam int PH = 6;   // clk cycles per sclk phase

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        sclk;
    logic [10:0] temp_in;
    logic        temp_valid;
    logic        sio;
    logic        sio_oe;
    logic        busy;
    logic        frame_done;
`ifdef LM07_CFG_WRITE_EN
    logic        sio_in;
    logic [15:0] cfg_reg;
`endif

    int n_cmp = 0;
    int n_err = 0;

    lm07_slave_model dut (
        .clk        (clk),
        .reset      (reset),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .sio        (sio),
        .sio_oe     (sio_oe),
        .busy       (busy),
`ifdef LM07_CFG_WRITE_EN
        .sio_in     (sio_in),
        .cfg_reg    (cfg_reg),
`endif
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [10:0] t);
        temp_in    = t;
        temp_valid = 1'b1;
        tick(1);
        temp_valid = 1'b0;
    endtask

    // One master frame. load_at = bit index for a mid-frame strobe, -1 for a
    // strobe coinciding with the detected cs_n fall, other negatives for none.
    task automatic frame(input int nfalls, input int load_at, input logic [10:0] load_val,
                         output logic [15:0] word, output int done_cnt,
                         output logic oe_early, output logic oe_lat,
                         output logic first_sio, output logic oe_after);
        word     = '0;
        done_cnt = 0;
        oe_after = 1'b1;
        cs_n = 1'b0;
        tick(2);
        oe_early = sio_oe;
        if (load_at == -1) begin
            temp_in    = load_val;
            temp_valid = 1'b1;
        end
        tick(1);
        temp_valid = 1'b0;
        oe_lat    = sio_oe;
        first_sio = sio;
        tick(PH - 3);
        for (int i = 0; i < nfalls; i++) begin
            if (i == load_at) strobe(load_val);
            if (i < 16) word[15 - i] = sio;
            sclk = 1'b0;
            tick(PH);
            sclk = 1'b1;
            tick(PH);
        end
        cs_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (k == 2) oe_after = sio_oe;
            if (frame_done === 1'b1) done_cnt++;
        end
        tick(PH);
    endtask

    logic [15:0] w;
    int          dc;
    logic        oe_e, oe_l, fs, oe_a;

    initial begin
        reset      = 1'b1;
        cs_n       = 1'b1;
        sclk       = 1'b1;
        temp_in    = '0;
        temp_valid = 1'b0;
`ifdef LM07_CFG_WRITE_EN
        sio_in     = 1'b0;
`endif
        tick(3);
        check("rst_sio",   16'(sio), 16'h0);
        check("rst_oe",    16'(sio_oe), 16'h0);
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_done",  16'(frame_done), 16'h0);
        reset = 1'b0;
        tick(6);
        check("idle_no_false_frame", 16'(sio_oe), 16'h0);

        // +25 C
        strobe(11'h064);
        tick(2);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame t25: word=%h done=%0d", w, dc);
        check("t25_word",     w, 16'h0C98);
        check("t25_done",     16'(dc), 16'd1);
        check("t25_oe_early", 16'(oe_e), 16'h0);
        check("t25_oe_lat",   16'(oe_l), 16'h1);
        check("t25_oe_after", 16'(oe_a), 16'h0);
        check("t25_busy_end", 16'(busy), 16'h0);

        // -25 C, sign bit visible before the first fall
        strobe(11'h79C);
        tick(2);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame m25: word=%h done=%0d", w, dc);
        check("m25_word",  w, 16'hF398);
        check("m25_sign",  16'(fs), 16'h1);
        check("m25_done",  16'(dc), 16'd1);

        // Mid-frame update affects only the next frame
        frame(16, 5, 11'h064, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame mid: word=%h done=%0d", w, dc);
        check("mid_word_snapshot", w, 16'hF398);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame next: word=%h done=%0d", w, dc);
        check("mid_next_word", w, 16'h0C98);

        // Short frame of 9 falls aborts silently
        frame(9, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame short: bits=%h done=%0d", w[15:7], dc);
        check("short_bits",     16'(w[15:7]), 16'h019);
        check("short_no_done",  16'(dc), 16'd0);
        check("short_oe_after", 16'(oe_a), 16'h0);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame after short: word=%h done=%0d", w, dc);
        check("after_short_word", w, 16'h0C98);
        check("after_short_done", 16'(dc), 16'd1);

        // Strobe coinciding with the detected cs_n fall is taken into the snapshot
        frame(16, -1, 11'h79C, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame simul: word=%h done=%0d", w, dc);
        check("simul_word", w, 16'hF398);

        // Reset at bit 8 with cs_n held low; hold register returns to +25 C
        cs_n = 1'b0;
        tick(PH);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            tick(PH);
            sclk = 1'b1;
            tick(PH);
        end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("midrst_sio",  16'(sio), 16'h0);
        check("midrst_oe",   16'(sio_oe), 16'h0);
        check("midrst_busy", 16'(busy), 16'h0);
        tick(20);
        check("midrst_no_restart", 16'(sio_oe), 16'h0);
        cs_n = 1'b1;
        tick(PH);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame after reset: word=%h done=%0d", w, dc);
        check("postrst_word", w, 16'h0C98);

`ifdef LM07_CFG_WRITE_EN
        check("cfg_reset", cfg_reg, 16'h0000);
        sio_in = 1'b1;
        frame(32, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame cfg write ffff: cfg=%h", cfg_reg);
        check("cfg_ffff", cfg_reg, 16'hFFFF);
        sio_in = 1'b0;
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame shutdown: word=%h", w);
        check("shutdown_id", w, 16'h800F);
        frame(32, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame cfg write 0000: cfg=%h", cfg_reg);
        check("cfg_0000", cfg_reg, 16'h0000);
        frame(16, -2, 11'h0, w, dc, oe_e, oe_l, fs, oe_a);
        $display("frame restored: word=%h", w);
        check("restored_word", w, 16'h0C98);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
